// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-ported data memory: CPU priority with
// anti-starvation for the debug master, locked debug bursts and registered read return.
module dmem_arbiter #(
    parameter logic [31:0] BASE_ADDR  = 32'h10010000,
    parameter int          AW         = 11,
    parameter int          STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [1:0]    cpu_fmt,
    output logic          cpu_gnt,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_rvalid,

    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [31:0]   dbg_addr,
    input  logic [31:0]   dbg_wdata,
    input  logic [1:0]    dbg_fmt,
    input  logic          dbg_lock,
    output logic          dbg_gnt,
    output logic [31:0]   dbg_rdata,
    output logic          dbg_rvalid,

    output logic          dm_r,
    output logic          dm_w,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_wdata,
    output logic [1:0]    dm_fmt,
    input  logic [31:0]   dm_rdata,

    output logic          addr_err
);

    // Handshake: a master holds req (with we/addr/wdata/fmt stable) until it sees gnt
    // in the same cycle; the access completes at that posedge. A granted read returns
    // data with a one-cycle rvalid pulse on the following cycle. Requests never queue.

    typedef enum logic [0:0] {
        PRIO_CPU = 1'b0,
        DBG_LOCK = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  starve_cnt;
    logic [3:0]  starve_nxt;

    logic        lock_hold;
    logic        any_gnt;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [1:0]  sel_fmt;
    logic        sel_bad;

    function automatic logic addr_bad(input logic [31:0] addr, input logic [1:0] fmt);
        logic [31:0] off;
        logic        below;
        logic        beyond;
        logic        misaligned;
        below      = (addr < BASE_ADDR);
        off        = addr - BASE_ADDR;
        beyond     = ((off >> (AW + 2)) != 32'd0);
        misaligned = ((fmt == 2'b00) && (addr[1:0] != 2'b00)) ||
                     ((fmt == 2'b01) && addr[0]);
        return below || beyond || misaligned;
    endfunction

    function automatic logic [AW-1:0] word_of(input logic [31:0] addr);
        return AW'((addr - BASE_ADDR) >> 2);
    endfunction

    // Arbitration and next-state
    always_comb begin
        cpu_gnt    = 1'b0;
        dbg_gnt    = 1'b0;
        lock_hold  = (state == DBG_LOCK) && dbg_lock;

        if (rst_n) begin
            if (lock_hold) begin
                dbg_gnt = dbg_req;
            end else if (dbg_req && (starve_cnt == STARVE_LIM)) begin
                dbg_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end else if (dbg_req) begin
                dbg_gnt = 1'b1;
            end
        end

        // The cycle dbg_lock drops is arbitrated as PRIO_CPU and leaves the lock.
        state_nxt = (lock_hold || (dbg_gnt && dbg_lock)) ? DBG_LOCK : PRIO_CPU;

        starve_nxt = starve_cnt;
        if (!dbg_req || dbg_gnt) begin
            starve_nxt = 4'd0;
        end else if (cpu_gnt && (starve_cnt < STARVE_LIM)) begin
            starve_nxt = starve_cnt + 4'd1;
        end
    end

    // Winner's request onto the memory port
    always_comb begin
        any_gnt   = cpu_gnt || dbg_gnt;
        sel_we    = dbg_gnt ? dbg_we    : cpu_we;
        sel_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
        sel_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
        sel_fmt   = dbg_gnt ? dbg_fmt   : cpu_fmt;
        sel_bad   = addr_bad(sel_addr, sel_fmt);

        dm_r      = 1'b0;
        dm_w      = 1'b0;
        dm_addr   = '0;
        dm_wdata  = 32'd0;
        dm_fmt    = 2'b00;
        if (any_gnt && !sel_bad) begin
            dm_r     = !sel_we;
            dm_w     = sel_we;
            dm_addr  = word_of(sel_addr);
            dm_wdata = sel_wdata;
            dm_fmt   = sel_fmt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= PRIO_CPU;
            starve_cnt <= 4'd0;
            cpu_rdata  <= 32'd0;
            dbg_rdata  <= 32'd0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            cpu_rvalid <= cpu_gnt && !cpu_we;
            dbg_rvalid <= dbg_gnt && !dbg_we;
            addr_err   <= any_gnt && sel_bad;
            // An illegal read still returns, but with zero data.
            if (cpu_gnt && !cpu_we) begin
                cpu_rdata <= sel_bad ? 32'd0 : dm_rdata;
            end
            if (dbg_gnt && !dbg_we) begin
                dbg_rdata <= sel_bad ? 32'd0 : dm_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural word memory behind the port.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [1:0]  cpu_fmt, dbg_fmt;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        dm_r, dm_w, addr_err;
    logic [10:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [1:0]  dm_fmt;
    logic [31:0] dm_rdata;

    logic [31:0] mem [0:2047];

    int total  = 0;
    int passed = 0;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_fmt(cpu_fmt), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_fmt(dbg_fmt), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
        .dbg_rvalid(dbg_rvalid),
        .dm_r(dm_r), .dm_w(dm_w), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_fmt(dm_fmt),
        .dm_rdata(dm_rdata), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dm_w) mem[dm_addr] <= dm_wdata;
    end
    assign dm_rdata = mem[dm_addr];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] fmt);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_fmt = fmt;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic lock,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] fmt);
        dbg_req = req; dbg_we = we; dbg_lock = lock; dbg_addr = addr;
        dbg_wdata = wdata; dbg_fmt = fmt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic err_read(input string tag, input logic [31:0] addr, input logic [1:0] fmt);
        set_cpu(1'b1, 1'b0, addr, 32'd0, fmt);
        #1;
        chk({tag, "_gnt"}, 32'(cpu_gnt), 32'd1);
        chk({tag, "_dm_r"}, 32'(dm_r), 32'd0);
        cyc();
        chk({tag, "_rvalid"}, 32'(cpu_rvalid), 32'd1);
        chk({tag, "_rdata"}, cpu_rdata, 32'd0);
        chk({tag, "_addr_err"}, 32'(addr_err), 32'd1);
    endtask

    initial begin
        logic exp_dbg;

        // Reset with requests active
        rst_n = 1'b0;
        set_cpu(1'b1, 1'b1, 32'h10010008, 32'h12345678, 2'b00);
        set_dbg(1'b1, 1'b1, 1'b1, 32'h10010004, 32'h87654321, 2'b00);
        #1;
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        chk("rst_dm_w", 32'(dm_w), 32'd0);
        cyc();
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);

        // CPU writes: word 2, word 0, last word
        rst_n = 1'b1;
        set_dbg(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
        set_cpu(1'b1, 1'b1, 32'h10010008, 32'hDEADBEEF, 2'b00);
        #1;
        chk("wr_gnt", 32'(cpu_gnt), 32'd1);
        chk("wr_dm_w", 32'(dm_w), 32'd1);
        chk("wr_dm_addr", 32'(dm_addr), 32'd2);
        chk("wr_dm_wdata", dm_wdata, 32'hDEADBEEF);
        cyc();
        set_cpu(1'b1, 1'b1, 32'h10010000, 32'hA5A50000, 2'b00);
        #1;
        chk("wr0_dm_addr", 32'(dm_addr), 32'd0);
        cyc();
        set_cpu(1'b1, 1'b1, 32'h10011FFC, 32'h0000FFFF, 2'b00);
        #1;
        chk("wr_top_dm_w", 32'(dm_w), 32'd1);
        chk("wr_top_dm_addr", 32'(dm_addr), 32'h7FF);
        cyc();

        // CPU read back of word 2
        set_cpu(1'b1, 1'b0, 32'h10010008, 32'd0, 2'b00);
        #1;
        chk("rd_dm_r", 32'(dm_r), 32'd1);
        chk("rd_dm_w", 32'(dm_w), 32'd0);
        chk("rd_dm_addr", 32'(dm_addr), 32'd2);
        cyc();
        chk("rd_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);
        set_cpu(1'b0, 1'b0, 32'h10010008, 32'd0, 2'b00);
        #1;
        chk("idle_dm_r", 32'(dm_r), 32'd0);
        chk("idle_dm_addr", 32'(dm_addr), 32'd0);
        cyc();
        chk("idle_rvalid", 32'(cpu_rvalid), 32'd0);

        // Contention: both reading word 2, dbg wins every 5th cycle
        set_cpu(1'b1, 1'b0, 32'h10010008, 32'd0, 2'b00);
        set_dbg(1'b1, 1'b0, 1'b0, 32'h10010008, 32'd0, 2'b00);
        for (int i = 0; i < 10; i++) begin
            exp_dbg = ((i % 5) == 4);
            #1;
            chk($sformatf("cont%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(!exp_dbg));
            chk($sformatf("cont%0d_dbg_gnt", i), 32'(dbg_gnt), 32'(exp_dbg));
            cyc();
            chk($sformatf("cont%0d_cpu_rvalid", i), 32'(cpu_rvalid), 32'(!exp_dbg));
            chk($sformatf("cont%0d_dbg_rvalid", i), 32'(dbg_rvalid), 32'(exp_dbg));
            if (exp_dbg) chk($sformatf("cont%0d_dbg_rdata", i), dbg_rdata, 32'hDEADBEEF);
        end

        // Locked debug burst writing word 4
        set_cpu(1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
        set_dbg(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
        cyc();
        set_dbg(1'b1, 1'b1, 1'b1, 32'h10010010, 32'hCAFE0004, 2'b00);
        #1;
        chk("lock0_dbg_gnt", 32'(dbg_gnt), 32'd1);
        chk("lock0_dm_w", 32'(dm_w), 32'd1);
        chk("lock0_dm_addr", 32'(dm_addr), 32'd4);
        cyc();
        set_cpu(1'b1, 1'b0, 32'h10010010, 32'd0, 2'b00);
        for (int i = 1; i < 3; i++) begin
            #1;
            chk($sformatf("lock%0d_cpu_gnt", i), 32'(cpu_gnt), 32'd0);
            chk($sformatf("lock%0d_dbg_gnt", i), 32'(dbg_gnt), 32'd1);
            cyc();
        end
        set_dbg(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 2'b00);
        #1;
        chk("lock_idle_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("lock_idle_dm_r", 32'(dm_r), 32'd0);
        cyc();
        set_dbg(1'b1, 1'b0, 1'b0, 32'h10010008, 32'd0, 2'b00);
        #1;
        chk("unlock_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("unlock_dbg_gnt", 32'(dbg_gnt), 32'd0);
        chk("unlock_dm_addr", 32'(dm_addr), 32'd4);
        cyc();
        chk("unlock_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("unlock_rdata", cpu_rdata, 32'hCAFE0004);

        // Lock requested while the CPU wins: no lock taken
        dbg_lock = 1'b1;
        #1;
        chk("nolock1_cpu_gnt", 32'(cpu_gnt), 32'd1);
        cyc();
        #1;
        chk("nolock2_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("nolock2_dbg_gnt", 32'(dbg_gnt), 32'd0);
        cyc();

        // Address errors and a legal byte read
        set_dbg(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
        err_read("below", 32'h1000FFFC, 2'b00);
        err_read("beyond", 32'h10012000, 2'b00);
        err_read("misalign", 32'h10010002, 2'b00);
        set_cpu(1'b1, 1'b0, 32'h10010002, 32'd0, 2'b10);
        #1;
        chk("byte_dm_r", 32'(dm_r), 32'd1);
        chk("byte_dm_addr", 32'(dm_addr), 32'd0);
        chk("byte_dm_fmt", 32'(dm_fmt), 32'd2);
        cyc();
        chk("byte_addr_err", 32'(addr_err), 32'd0);
        chk("byte_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("byte_rdata", cpu_rdata, 32'hA5A50000);

        // Reset during a locked debug read
        set_cpu(1'b0, 1'b0, 32'd0, 32'd0, 2'b00);
        set_dbg(1'b1, 1'b0, 1'b1, 32'h10010008, 32'd0, 2'b00);
        #1;
        chk("rlock_dbg_gnt", 32'(dbg_gnt), 32'd1);
        cyc();
        chk("rlock_dbg_rvalid", 32'(dbg_rvalid), 32'd1);
        rst_n = 1'b0;
        set_cpu(1'b1, 1'b0, 32'h10010008, 32'd0, 2'b00);
        #1;
        chk("rlock_rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        chk("rlock_rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        cyc();
        chk("rlock_rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        chk("rlock_rst_dbg_rdata", dbg_rdata, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("post_rst_dbg_gnt", 32'(dbg_gnt), 32'd0);
        cyc();
        chk("post_rst_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("post_rst_rdata", cpu_rdata, 32'hDEADBEEF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter for the single-ported data memory of the `sccomp_dataflow` system, sitting between the `cpu` data port and `dmem`. A second master (debug/loader port) shares that memory. The block:
- maps 32-bit byte addresses to word addresses,
- arbitrates with CPU priority plus anti-starvation and locked debug bursts,
- registers read data back to the winning requester.

## Interface
Parameters:
- BASE_ADDR, 32'h10010000, byte address of dmem word 0
- AW, 11, dmem word-address width
- STARVE_MAX, 4, consecutive lost cycles after which dbg wins one cycle (1..15)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_fmt  in  2  store/load format: 00 word, 01 half, 10 byte
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_rdata  out  32  registered read data
- cpu_rvalid  out  1  cpu_rdata valid (one cycle after read grant)
- dbg_req, dbg_we, dbg_addr[31:0], dbg_wdata[31:0], dbg_fmt[1:0]  in  same meaning for debug master
- dbg_lock  in  1  hold ownership across cycles while high
- dbg_gnt, dbg_rdata[31:0], dbg_rvalid  out  same meaning for debug master
- dm_r, dm_w  out  1  dmem read/write strobes
- dm_addr  out  AW  word address
- dm_wdata  out  32  write data
- dm_fmt  out  2  to dmem store_format_signal
- dm_rdata  in  32  dmem combinational read data
- addr_err  out  1  registered pulse: granted access was out of range or misaligned

## Operation
- Address map: word = (addr − BASE_ADDR) >> 2, truncated to AW bits.
- Address is illegal if any of these hold:
  - addr < BASE_ADDR
  - (addr − BASE_ADDR) >> 2 ≥ 2^AW
  - fmt=00 and addr[1:0]≠0
  - fmt=01 and addr[0]≠0
- Illegal granted access: dm_r = dm_w = 0. For a read, rvalid still pulses with rdata = 0. addr_err pulses next cycle.
- FSM states:
  - PRIO_CPU: CPU wins whenever cpu_req. Dbg wins if only dbg_req, or if starve_cnt == STARVE_MAX.
  - DBG_LOCK: dbg owns the port; cpu_gnt = 0 regardless of cpu_req.
- Transitions:
  - PRIO_CPU → DBG_LOCK when dbg granted with dbg_lock = 1.
  - DBG_LOCK → PRIO_CPU on the first cycle dbg_lock = 0. That cycle is arbitrated normally as PRIO_CPU.
  - In DBG_LOCK with dbg_req = 0 and dbg_lock = 1, state holds and the port idles.
- starve_cnt (4-bit):
  - increments when dbg_req = 1 and cpu wins;
  - clears when dbg is granted, or when dbg_req = 0;
  - saturates at STARVE_MAX.
- Grant and dm_* outputs are combinational from state, req and addr within the same cycle. At most one gnt is high per cycle.
- No request: dm_r = dm_w = 0, dm_addr / dm_wdata / dm_fmt = 0.
- Read return: on a granted read, dm_rdata is captured at posedge into the winner's rdata, and rvalid is high the following cycle. The other master's rdata holds its last value.

## Timing
- Reset (rst_n = 0 at posedge) values:
  - state = PRIO_CPU, starve_cnt = 0
  - cpu_rdata = dbg_rdata = 0
  - cpu_rvalid = dbg_rvalid = 0, addr_err = 0
  - Combinational outputs follow inputs but are forced low (gnt, dm_r, dm_w) while rst_n = 0.
- Write latency 0: dmem writes at the same posedge the grant is seen. Read latency 1 cycle; rvalid is a single-cycle pulse per granted read.
- Reset asserted mid-lock returns to PRIO_CPU. Reset during a pending read suppresses its rvalid.
- Back-to-back reads by the same master give rvalid on consecutive cycles.
- Simultaneous req with dbg_lock = 1 while the CPU wins (starve_cnt < STARVE_MAX): no lock is taken; starve_cnt increments.

## Test plan
- Reset: drive requests with rst_n = 0 → all gnt = 0, dm_w = 0, rvalid = 0. After release the first cpu_req is granted.
- CPU write then read at 0x10010008: dm_addr = 2, dm_w pulse. Read of the same address gives cpu_rvalid the next cycle with the written data.
- Contention, STARVE_MAX = 4, both reqs held high: cpu_gnt for 4 cycles, dbg_gnt on the 5th cycle, repeating with period 5.
- Lock burst: dbg wins with dbg_lock = 1 for 3 cycles while cpu_req stays high → cpu_gnt = 0 throughout. The CPU is granted the cycle dbg_lock drops.
- Errors: read 0x1000FFFC, read 0x10012000 (AW = 11), and word read at 0x10010002 → no dm_r, rvalid with rdata 0, addr_err pulse each. A byte read at 0x10010002 is legal with dm_addr = 0.
- Reset asserted during DBG_LOCK with a read pending → no rvalid. Next cycle the CPU wins priority.
